// File: rtl/psg_stereo_core.sv
// -----------------------------------------------------------------------------
// psg_stereo_core
//
// SN76489-compatible programmable sound generator with stereo panning:
// three square-wave tone channels and one LFSR noise channel, programmed with
// the SN76489 latch/data byte protocol, mixed into independent left and right
// outputs through a per-channel pan enable register.
//
// Ports
//   clk        system clock, all flops rising-edge
//   reset      asynchronous active-high reset, clears all state immediately
//   wr_en      SN76489 byte write strobe (one byte per cycle, always accepted)
//   wr_data    latch/data byte
//   pan_en     stereo pan register write strobe
//   pan_data   [7:4] left enables, [3:0] right enables (bit i = channel i,
//              channel 3 = noise)
//   left_out   registered left mix, MASTER_OUTPUT_BITS wide
//   right_out  registered right mix, MASTER_OUTPUT_BITS wide
//   tick       master strobe from the clock divider (combinational)
// -----------------------------------------------------------------------------
module psg_stereo_core #(
  parameter int CHANNEL_OUTPUT_BITS = 10,  // per-channel volume width (8..12)
  parameter int MASTER_OUTPUT_BITS  = 8,   // output width, <= CHANNEL_OUTPUT_BITS+2
  parameter int COUNTER_BITS        = 10,  // tone frequency register width
  parameter int CLOCK_DIV           = 16   // power of two, >= 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          pan_en,
  input  logic [7:0]                    pan_data,
  output logic [MASTER_OUTPUT_BITS-1:0] left_out,
  output logic [MASTER_OUTPUT_BITS-1:0] right_out,
  output logic                          tick
);

  localparam int B     = CHANNEL_OUTPUT_BITS;
  localparam int M     = MASTER_OUTPUT_BITS;
  localparam int CB    = COUNTER_BITS;
  localparam int HI_W  = CB - 4;   // frequency bits carried by a data byte
  localparam int SUM_W = B + 2;    // four channels summed cannot overflow this

  // Register codes carried in a latch byte's bits [6:4].
  localparam logic [2:0] REG_NOISE_CTRL = 3'b110;

  // ---------------------------------------------------------------------------
  // Master strobe divider. A power-of-two counter wraps on its own, so no
  // terminal-count compare is needed.
  // ---------------------------------------------------------------------------
  generate
    if (CLOCK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLOCK_DIV);
      logic [DW-1:0] div_cnt;

      // NOTE: every flop is written with <= so all sequential blocks see the
      // pre-edge value of every other flop, independent of block ordering.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= div_cnt + 1'b1;
      end

      assign tick = (div_cnt == '0);
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Attenuation table: level(a) = floor((2^B-1) * 10^(-a/10)), 2 dB per step,
  // with code 15 meaning silence. Evaluated entirely at elaboration time.
  // ---------------------------------------------------------------------------
  function automatic logic [B-1:0] level_f(input int a);
    real full_scale;
    real lvl;
    if (a >= 15) return '0;
    full_scale = real'((1 << B) - 1);
    lvl        = full_scale * (10.0 ** (-real'(a) / 10.0));
    return B'($rtoi(lvl));  // truncation equals floor for a positive value
  endfunction

  logic [B-1:0] level_tab [16];

  generate
    for (genvar a = 0; a < 16; a++) begin : g_level
      localparam logic [B-1:0] LVL = level_f(a);
      assign level_tab[a] = LVL;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Programming registers
  // ---------------------------------------------------------------------------
  logic [CB-1:0] freq [3];
  logic [3:0]    attn [4];
  logic [2:0]    noise_ctrl;
  logic [2:0]    latch;
  logic [7:0]    pan;

  // A latch byte addressed to the noise control register restarts the noise
  // generator in the same edge that updates noise_ctrl.
  logic noise_restart;
  assign noise_restart = wr_en && wr_data[7] && (wr_data[6:4] == REG_NOISE_CTRL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these arrays are a handful of flops, not a RAM, so giving them a
      // reset value costs nothing and keeps power-up silent.
      for (int i = 0; i < 3; i++) freq[i] <= '0;
      for (int i = 0; i < 4; i++) attn[i] <= 4'hF;
      noise_ctrl <= 3'b100;
      latch      <= 3'b000;
      pan        <= 8'hFF;
    end else begin
      if (wr_en) begin
        if (wr_data[7]) begin
          // Latch byte: selects the register and carries its low bits.
          latch <= wr_data[6:4];
          if (wr_data[4])                attn[wr_data[6:5]] <= wr_data[3:0];
          else if (wr_data[6:5] == 2'd3) noise_ctrl         <= wr_data[2:0];
          else                           freq[wr_data[6:5]][3:0] <= wr_data[3:0];
        end else begin
          // Data byte: completes the latched register; noise ignores it.
          if (latch[0])
            attn[latch[2:1]] <= wr_data[3:0];
          else if (latch[2:1] != 2'd3)
            freq[latch[2:1]][CB-1:4] <= HI_W'(wr_data[5:0]);
        end
      end
      if (pan_en) pan <= pan_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Tone generators. A frequency of 0 or 1 parks the channel at DC high.
  // Otherwise the output toggles every freq ticks.
  // ---------------------------------------------------------------------------
  logic [CB-1:0] tone_cnt [3];
  logic [2:0]    tone_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) tone_cnt[i] <= '0;
      tone_out <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (freq[i] <= CB'(1)) begin
          tone_out[i] <= 1'b1;
          tone_cnt[i] <= '0;
        end else if (tone_cnt[i] == '0) begin
          tone_cnt[i] <= freq[i] - 1'b1;
          tone_out[i] <= ~tone_out[i];
        end else begin
          tone_cnt[i] <= tone_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Tone 2 goes 0 -> 1 on this tick: it is low now and either parks at DC or
  // reaches its toggle point. Drives the noise clock in rate mode 11.
  logic tone2_rise;
  assign tone2_rise = tick && !tone_out[2] &&
                      ((freq[2] <= CB'(1)) || (tone_cnt[2] == '0));

  // ---------------------------------------------------------------------------
  // Noise generator. In rates 00/01/10 a toggle flop inverts every N ticks
  // and the LFSR shifts on its rising edge, i.e. every 2N ticks.
  // ---------------------------------------------------------------------------
  logic [5:0]  noise_div;
  logic        noise_tgl;
  logic [14:0] lfsr;
  logic [5:0]  noise_top;
  logic        lfsr_fb;
  logic        lfsr_shift;

  always_comb begin
    // NOTE: every variable an always_comb writes gets a value before any
    // branch, so no path can leave it holding state and infer a latch.
    noise_top  = 6'd63;
    lfsr_shift = 1'b0;
    case (noise_ctrl[1:0])
      2'b00:   noise_top = 6'd15;
      2'b01:   noise_top = 6'd31;
      default: noise_top = 6'd63;
    endcase
    if (tick) begin
      if (noise_ctrl[1:0] == 2'b11) lfsr_shift = tone2_rise;
      else                          lfsr_shift = (noise_div == noise_top) && !noise_tgl;
    end
  end

  // White noise taps bits 0 and 1; periodic noise recirculates bit 0.
  assign lfsr_fb = noise_ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      noise_div <= '0;
      noise_tgl <= 1'b0;
      lfsr      <= 15'h4000;
    end else if (noise_restart) begin
      // Restart wins over any shift that would have happened on this edge.
      noise_div <= '0;
      noise_tgl <= 1'b0;
      lfsr      <= 15'h4000;
    end else begin
      if (tick && (noise_ctrl[1:0] != 2'b11)) begin
        if (noise_div == noise_top) begin
          noise_div <= '0;
          noise_tgl <= ~noise_tgl;
        end else begin
          noise_div <= noise_div + 1'b1;
        end
      end
      if (lfsr_shift) lfsr <= {lfsr_fb, lfsr[14:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Stereo mix. Each side sums the volumes of its enabled channels; the
  // output keeps the top M bits of the B+2-bit sum.
  // ---------------------------------------------------------------------------
  logic [3:0]       chan_on;
  logic [SUM_W-1:0] sum_l;
  logic [SUM_W-1:0] sum_r;

  assign chan_on = {lfsr[0], tone_out};

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < 4; i++) begin
      if (chan_on[i]) begin
        if (pan[4+i]) sum_l = sum_l + SUM_W'(level_tab[attn[i]]);
        if (pan[i])   sum_r = sum_r + SUM_W'(level_tab[attn[i]]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_out  <= '0;
      right_out <= '0;
    end else begin
      left_out  <= sum_l[SUM_W-1 -: M];
      right_out <= sum_r[SUM_W-1 -: M];
    end
  end

endmodule

// File: tb/tb_psg_stereo_core.sv
// -----------------------------------------------------------------------------
// tb_psg_stereo_core
//
// Drives two instances (CLOCK_DIV = 1 and CLOCK_DIV = 16) with identical
// stimulus and compares every cycle against a behavioural model of the sound
// generator, then checks the directed scenarios with constant expectations.
// -----------------------------------------------------------------------------
module tb_psg_stereo_core;

  localparam int B  = 10;
  localparam int M  = 8;
  localparam int CB = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         pan_en;
  logic [7:0]   pan_data;
  logic [M-1:0] left_f, right_f, left_s, right_s;
  logic         tick_f, tick_s;

  always #5 clk = ~clk;

  psg_stereo_core #(
    .CHANNEL_OUTPUT_BITS(B), .MASTER_OUTPUT_BITS(M),
    .COUNTER_BITS(CB), .CLOCK_DIV(1)
  ) dut_fast (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .pan_en(pan_en), .pan_data(pan_data),
    .left_out(left_f), .right_out(right_f), .tick(tick_f)
  );

  psg_stereo_core #(
    .CHANNEL_OUTPUT_BITS(B), .MASTER_OUTPUT_BITS(M),
    .COUNTER_BITS(CB), .CLOCK_DIV(16)
  ) dut_slow (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .pan_en(pan_en), .pan_data(pan_data),
    .left_out(left_s), .right_out(right_s), .tick(tick_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int ref_level [16];
  int r_freq [3];
  int r_attn [4];
  int r_nctrl, r_latch, r_pan;

  int m_cycle [2];     // clocks since reset; tick when a multiple of the divider
  int m_cnt   [2][3];  // ticks left before the next tone toggle
  bit m_out   [2][3];
  int m_nt    [2];     // ticks since the last noise restart
  int m_lfsr  [2];
  int m_left  [2];
  int m_right [2];

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 16;
  endfunction

  function automatic bit m_tick(input int d);
    return (m_cycle[d] % div_of(d)) == 0;
  endfunction

  task automatic build_levels();
    for (int a = 0; a < 16; a++) begin
      if (a == 15) ref_level[a] = 0;
      else ref_level[a] = int'($floor(real'((1 << B) - 1) * $pow(10.0, -real'(a) / 10.0)));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) r_freq[i] = 0;
    for (int i = 0; i < 4; i++) r_attn[i] = 15;
    r_nctrl = 4;
    r_latch = 0;
    r_pan   = 'hFF;
    for (int d = 0; d < 2; d++) begin
      m_cycle[d] = 0;
      for (int i = 0; i < 3; i++) begin
        m_cnt[d][i] = 0;
        m_out[d][i] = 1'b0;
      end
      m_nt[d]    = 0;
      m_lfsr[d]  = 'h4000;
      m_left[d]  = 0;
      m_right[d] = 0;
    end
  endtask

  task automatic lfsr_step(input int d);
    int l, fb;
    l = m_lfsr[d];
    if ((r_nctrl >> 2) & 1) fb = (l ^ (l >> 1)) & 1;
    else                    fb = l & 1;
    m_lfsr[d] = (l >> 1) | (fb << 14);
  endtask

  // One rising clock edge: outputs from the pre-edge state, generators with
  // the pre-edge registers, then the writes of this edge.
  task automatic model_edge(input bit we, input logic [7:0] wd,
                            input bit pe, input logic [7:0] pd);
    bit restart, tk, old2, rise2, on;
    int sl, sr, n, ch;
    restart = we && wd[7] && (wd[6:4] == 3'd6);
    for (int d = 0; d < 2; d++) begin
      sl = 0;
      sr = 0;
      for (int i = 0; i < 4; i++) begin
        on = (i < 3) ? m_out[d][i] : bit'(m_lfsr[d] & 1);
        if (on && ((r_pan >> (4 + i)) & 1) != 0) sl += ref_level[r_attn[i]];
        if (on && ((r_pan >> i) & 1) != 0)       sr += ref_level[r_attn[i]];
      end
      m_left[d]  = sl >> (B + 2 - M);
      m_right[d] = sr >> (B + 2 - M);

      tk   = m_tick(d);
      old2 = m_out[d][2];
      if (tk) begin
        for (int i = 0; i < 3; i++) begin
          if (r_freq[i] <= 1) begin
            m_out[d][i] = 1'b1;
            m_cnt[d][i] = 0;
          end else if (m_cnt[d][i] == 0) begin
            m_out[d][i] = !m_out[d][i];
            m_cnt[d][i] = r_freq[i] - 1;
          end else begin
            m_cnt[d][i]--;
          end
        end
      end
      rise2 = tk && !old2 && m_out[d][2];

      if (restart) begin
        m_nt[d]   = 0;
        m_lfsr[d] = 'h4000;
      end else if (tk) begin
        if ((r_nctrl & 3) == 3) begin
          if (rise2) lfsr_step(d);
        end else begin
          n = 16 << (r_nctrl & 3);
          m_nt[d]++;
          if (m_nt[d] % (2 * n) == n) lfsr_step(d);
        end
      end
      m_cycle[d]++;
    end

    if (we) begin
      if (wd[7]) begin
        r_latch = int'(wd[6:4]);
        ch      = r_latch / 2;
        if (r_latch % 2 == 1)  r_attn[ch] = int'(wd[3:0]);
        else if (r_latch == 6) r_nctrl    = int'(wd[2:0]);
        else                   r_freq[ch] = (r_freq[ch] & 'h3F0) | int'(wd[3:0]);
      end else begin
        ch = r_latch / 2;
        if (r_latch % 2 == 1)  r_attn[ch] = int'(wd[3:0]);
        else if (r_latch != 6) r_freq[ch] = (r_freq[ch] & 'hF) | (int'(wd[5:0]) << 4);
      end
    end
    if (pe) r_pan = int'(pd);
  endtask

  task automatic compare();
    check("tick_fast",  int'(tick_f),  int'(m_tick(0)));
    check("tick_slow",  int'(tick_s),  int'(m_tick(1)));
    check("left_fast",  int'(left_f),  m_left[0]);
    check("right_fast", int'(right_f), m_right[0]);
    check("left_slow",  int'(left_s),  m_left[1]);
    check("right_slow", int'(right_s), m_right[1]);
  endtask

  // Present inputs, take one edge in DUT and model, compare at the falling edge.
  task automatic step(input bit we, input logic [7:0] wd,
                      input bit pe, input logic [7:0] pd);
    wr_en    = we;
    wr_data  = wd;
    pan_en   = pe;
    pan_data = pd;
    @(posedge clk);
    model_edge(we, wd, pe, pd);
    @(negedge clk);
    wr_en  = 1'b0;
    pan_en = 1'b0;
    compare();
  endtask

  task automatic wr(input logic [7:0] b);
    step(1'b1, b, 1'b0, 8'h00);
  endtask

  task automatic set_pan(input logic [7:0] p);
    step(1'b0, 8'h00, 1'b1, p);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Run n idle cycles, counting fast-instance cycles at value v and maxima.
  task automatic observe(input int n, input int v, output int cnt_l, output int cnt_r,
                         output int max_l, output int max_r);
    cnt_l = 0; cnt_r = 0; max_l = 0; max_r = 0;
    for (int i = 0; i < n; i++) begin
      idle();
      if (int'(left_f) == v)  cnt_l++;
      if (int'(right_f) == v) cnt_r++;
      if (int'(left_f) > max_l)  max_l = int'(left_f);
      if (int'(right_f) > max_r) max_r = int'(right_f);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int kind;
    logic [2:0] sel;
    kind = $urandom_range(0, 15);
    sel  = 3'($urandom_range(0, 7));
    if (sel == 3'd6 && $urandom_range(0, 1) == 0) sel = 3'd7;
    if (kind < 8)   return {1'b1, sel, 4'($urandom_range(0, 15))};
    if (kind < 12)  return {6'b000000, 2'($urandom_range(0, 3))};
    if (kind < 15)  return {4'b0000, 4'($urandom_range(0, 15))};
    return 8'($urandom);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int exp_peak [16] = '{63, 50, 40, 32, 25, 20, 16, 12, 10, 8, 6, 5, 4, 3, 2, 0};

  initial begin
    int cl, cr, ml, mr, first, found, nt_f, nt_s;
    bit we, pe;
    logic [7:0] wd, pd;

    build_levels();
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; pan_en = 1'b0; pan_data = '0;
    @(negedge clk);
    check("reset_left_fast",  int'(left_f),  0);
    check("reset_right_fast", int'(right_f), 0);
    check("reset_left_slow",  int'(left_s),  0);
    check("reset_tick_slow",  int'(tick_s),  1);
    model_reset();
    reset = 1'b0;

    // Tone 0 at freq 32, full volume, both sides: 64-clock square of 0/63.
    wr(8'h80); wr(8'h02); wr(8'h90);
    observe(256, 63, cl, cr, ml, mr);
    check("tone0_left_high",  cl, 128);
    check("tone0_right_high", cr, 128);
    check("tone0_left_peak",  ml, 63);

    // Mute tone 0: silent from the second edge after the write.
    wr(8'h9F);
    idle();
    check("mute_left",  int'(left_f),  0);
    check("mute_right", int'(right_f), 0);
    wr(8'h92);
    observe(128, 40, cl, cr, ml, mr);
    check("attn2_peak_left",  ml, 40);
    check("attn2_peak_right", mr, 40);

    // Every attenuation step against the published B=10 table.
    for (int a = 0; a < 16; a++) begin
      wr(8'h90 | 8'(a));
      observe(70, 0, cl, cr, ml, mr);
      check($sformatf("attn_peak_%0d", a), ml, exp_peak[a]);
    end

    // Pan: right only, then left only.
    wr(8'h90);
    set_pan(8'h0F);
    observe(128, 63, cl, cr, ml, mr);
    check("pan_right_only_left_max", ml, 0);
    check("pan_right_only_right_hi", cr, 64);
    set_pan(8'h10);
    observe(128, 63, cl, cr, ml, mr);
    check("pan_left_only_right_max", mr, 0);
    check("pan_left_only_left_hi",   cl, 64);

    // Periodic noise, N=16: one high state in 15, each lasting 32 clocks.
    wr(8'h9F);
    set_pan(8'h88);
    wr(8'hF0);
    wr(8'hE0);
    observe(960, 63, cl, cr, ml, mr);
    check("periodic_noise_high", cl, 64);

    // White noise: first high state after the 14th shift.
    wr(8'hE4);
    first = 0;
    for (int j = 1; j <= 1000; j++) begin
      idle();
      if (int'(left_f) == 63) begin
        first = j;
        break;
      end
    end
    check("white_first_high", first, 433);

    // Noise clocked by tone 2 (freq 8): shift every 16 ticks.
    wr(8'hC8);
    wr(8'hE3);
    observe(500, 63, cl, cr, ml, mr);
    check("tone2_clocked_noise_high", cl, 32);

    // Tick pacing of both instances.
    nt_f = 0; nt_s = 0;
    for (int i = 0; i < 64; i++) begin
      idle();
      nt_f += int'(tick_f);
      nt_s += int'(tick_s);
    end
    check("ticks_fast_64", nt_f, 64);
    check("ticks_slow_64", nt_s, 4);

    // Asynchronous reset in the middle of a running tone.
    wr(8'hFF); set_pan(8'hFF); wr(8'h80); wr(8'h02); wr(8'h90);
    found = 0;
    for (int j = 0; j < 200; j++) begin
      idle();
      if (int'(left_f) == 63) begin
        found = 1;
        break;
      end
    end
    check("tone_before_reset", found, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_left_fast",  int'(left_f),  0);
    check("async_reset_right_fast", int'(right_f), 0);
    check("async_reset_left_slow",  int'(left_s),  0);
    check("async_reset_right_slow", int'(right_s), 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    observe(100, 0, cl, cr, ml, mr);
    check("post_reset_silent_left",  ml, 0);
    check("post_reset_silent_right", mr, 0);

    // Randomized programming traffic, checked every cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      we = ($urandom_range(0, 15) == 0);
      pe = ($urandom_range(0, 63) == 0);
      wd = we ? rand_byte() : 8'h00;
      pd = 8'($urandom);
      step(we, wd, pe, pd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psg_stereo_core.md
# psg_stereo_core

Parametrised successor to the team's SN76489-compatible sound generator: three square-wave tone channels plus one LFSR noise channel, programmed through the standard SN76489 latch/data byte protocol. It adds a Game Gear–style stereo pan register, independent left/right master mixes, a parametrised master-clock divider and parametrised channel/master widths. It sits between the CPU-facing register bus and the DAC/PWM output stage, and is fully self-contained.

## Interface
- CHANNEL_OUTPUT_BITS, 10: per-channel volume width B (8..12).
- MASTER_OUTPUT_BITS, 8: left/right output width M (M ≤ B+2).
- COUNTER_BITS, 10: tone frequency register width.
- CLOCK_DIV, 16: master-strobe divider; power of two, ≥1 (1 = strobe every clk).
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_en  input  1  SN76489 byte write strobe; one byte per cycle, always accepted.
- wr_data  input  8  latch/data byte.
- pan_en  input  1  stereo register write strobe.
- pan_data  input  8  [7:4] left enables, [3:0] right enables; bit i = channel i (3 = noise).
- left_out  output  M  registered left mix.
- right_out  output  M  registered right mix.
- tick  output  1  master strobe (combinational, from divider), for downstream sample pacing.

## Operation
- Divider: free-running log2(CLOCK_DIV)-bit counter, reset 0; tick = (counter == 0). For CLOCK_DIV=1, tick is held 1.
- Latch byte (bit7=1): latch <= wr_data[6:4]; 000/010/100 → tone0/1/2 freq[3:0] <= data[3:0]; 110 → noise_ctrl <= data[2:0] plus noise restart; odd codes 001/011/101/111 → attn[0..3] <= data[3:0].
- Data byte (bit7=0): latched tone → freq[9:4] <= data[5:0]; latched attn → attn <= data[3:0]; latched noise → ignored.
- Reset state: attn all 4'hF, freq all 0, noise_ctrl 3'b100, latch 0, pan 8'hFF, tone outs 0, tone counters 0, LFSR 15'h4000, outputs 0.
- Tone (on tick): if freq ≤ 1, out <= 1 and counter <= 0 (DC). Else if counter == 0, counter <= freq−1 and out <= ~out; otherwise counter decrements. Half-period = freq ticks.
- Noise rate, noise_ctrl[1:0]: 00/01/10 → N = 16/32/64. A noise toggle flop inverts every N ticks; the LFSR shifts on its 0→1 edge (every 2N ticks). 11 → LFSR shifts on any tick where tone2 out goes 0→1.
- LFSR: 15-bit, shift right; new bit14 = noise_ctrl[2] ? (bit0 ^ bit1) : bit0. Noise channel out = bit0.
- Restart (noise latch write): LFSR <= 15'h4000, noise divider and toggle <= 0, in the same edge as the register update.
- Attenuation: level(a) = floor((2^B−1)·10^(−a/10)) for a < 15, and 0 for a = 15 (2 dB steps). Elaboration-time table; for B=10: 1023, 812, 645, 512, 407, 323, 256, 204, 162, 128, 102, 81, 64, 51, 40, 0. Channel volume = out ? level(attn) : 0.
- Mix: side sum = Σ volume[i]·enable[i], width B+2 (cannot overflow). left_out/right_out <= sum[B+1 -: M].
- wr_en and pan_en in the same cycle: both are applied. Writes are independent of tick.

## Timing
- Register write at edge k is visible to generators from edge k; its audible effect appears at the first tick after it.
- Outputs are registered: a channel output/attn/pan change at edge k shows on left_out/right_out after edge k+1.
- Reset assertion forces all flops, including outputs, to reset values without a clock. Deassertion is synchronized by the integrator. A write coincident with reset is lost.
- Divider keeps running across writes; noise restart does not reset the divider.

## Test plan
- CLOCK_DIV=1, write 0x80, 0x02 (tone0 freq=32), 0x90 (attn0=0) → left_out and right_out alternate 0/63 with a 64-clk period; every other output stays 0.
- Write 0x9F after the above → both outputs 0 from the second edge after the write; 0x92 → peak 645>>4 = 40.
- pan 0x0F with tone0 running → left_out constant 0, right_out toggles 0/63; pan 0x10 → left only.
- Write 0xE0 (periodic, N=16) and 0xF0 → noise output high for exactly 1 shift in every 15 (shift every 32 clks at CLOCK_DIV=1); 0xE4 white → first high after the 14th shift, and the sequence repeats after 32767 shifts.
- Write 0xE3 with tone2 freq=8 → LFSR shifts every 16 ticks, aligned to tone2 rising edges; CLOCK_DIV=16 → all periods ×16, tick pulses every 16 clks.
- Assert reset mid-tone (asynchronously, between edges) → left_out/right_out = 0 immediately; after release, attn=F gives silence until it is reprogrammed.
